// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Shared definitions for the write-side FIFO arbiter: FSM state encoding,
//   default FIFO word width and producer index constants.
package fifo_wr_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SEND_LO = 2'b01,
    SEND_HI = 2'b10
  } state_t;

  // Producer indices: register-file read path and ALU result path.
  localparam logic REQ_RF  = 1'b0;
  localparam logic REQ_ALU = 1'b1;

endpackage

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single async-FIFO write port between two producers. A granted
//   1- or 2-byte frame is latched into a hold register and written low byte
//   first, stalling on W_FULL. Frames are atomic; ties are broken round-robin.
//
// Ports
//   W_CLK                      write-domain clock
//   W_RST                      asynchronous active-low reset
//   REQ0_VLD/_DATA/_TWO/_ACK   producer 0 handshake, payload, length, capture pulse
//   REQ1_VLD/_DATA/_TWO/_ACK   producer 1, same as producer 0
//   W_FULL                     registered FIFO full flag
//   WR_DATA                    FIFO write data
//   W_INC                      FIFO write strobe
//   BUSY                       high whenever a frame is in flight
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no frame held; sample requests and grant one
// SEND_LO | writing hold low byte; stalls while W_FULL
// SEND_HI | writing hold high byte (2-byte frames only); stalls on W_FULL
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    W_CLK,
  input  logic                    W_RST,
  input  logic                    REQ0_VLD,
  input  logic [2*DATA_WIDTH-1:0] REQ0_DATA,
  input  logic                    REQ0_TWO,
  output logic                    REQ0_ACK,
  input  logic                    REQ1_VLD,
  input  logic [2*DATA_WIDTH-1:0] REQ1_DATA,
  input  logic                    REQ1_TWO,
  output logic                    REQ1_ACK,
  input  logic                    W_FULL,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    W_INC,
  output logic                    BUSY
);

  state_t                  state;
  logic [2*DATA_WIDTH-1:0] hold;
  logic                    hold_two;
  logic                    last_grant;
  logic                    pick;

  // Producer 0 wins when it is alone, or on a tie when producer 1 went last.
  always_comb begin
    pick = REQ_ALU;
    if (REQ0_VLD && (!REQ1_VLD || last_grant == REQ_ALU)) pick = REQ_RF;
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      state      <= IDLE;
      hold       <= '0;
      hold_two   <= 1'b0;
      last_grant <= REQ_ALU;
      REQ0_ACK   <= 1'b0;
      REQ1_ACK   <= 1'b0;
    end else begin
      REQ0_ACK <= 1'b0;
      REQ1_ACK <= 1'b0;
      unique case (state)
        IDLE: begin
          if (REQ0_VLD || REQ1_VLD) begin
            if (pick == REQ_RF) begin
              hold     <= REQ0_DATA;
              hold_two <= REQ0_TWO;
              REQ0_ACK <= 1'b1;
            end else begin
              hold     <= REQ1_DATA;
              hold_two <= REQ1_TWO;
              REQ1_ACK <= 1'b1;
            end
            last_grant <= pick;
            state      <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (!W_FULL) state <= hold_two ? SEND_HI : IDLE;
        end
        SEND_HI: begin
          if (!W_FULL) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data comes straight from hold, so it stays stable across a stall.
  always_comb begin
    WR_DATA = '0;
    W_INC   = 1'b0;
    unique case (state)
      SEND_LO: begin
        WR_DATA = hold[DATA_WIDTH-1:0];
        W_INC   = ~W_FULL;
      end
      SEND_HI: begin
        WR_DATA = hold[2*DATA_WIDTH-1:DATA_WIDTH];
        W_INC   = ~W_FULL;
      end
      default: begin
        WR_DATA = '0;
        W_INC   = 1'b0;
      end
    endcase
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        W_CLK = 1'b0;
  logic        W_RST = 1'b0;
  logic        REQ0_VLD = 1'b0;
  logic [15:0] REQ0_DATA = '0;
  logic        REQ0_TWO = 1'b0;
  logic        REQ0_ACK;
  logic        REQ1_VLD = 1'b0;
  logic [15:0] REQ1_DATA = '0;
  logic        REQ1_TWO = 1'b0;
  logic        REQ1_ACK;
  logic        W_FULL = 1'b0;
  logic [7:0]  WR_DATA;
  logic        W_INC;
  logic        BUSY;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_bytes[$];
  int         exp_grants[$];

  fifo_wr_arbiter #(.DATA_WIDTH(8)) dut (
    .W_CLK(W_CLK), .W_RST(W_RST),
    .REQ0_VLD(REQ0_VLD), .REQ0_DATA(REQ0_DATA), .REQ0_TWO(REQ0_TWO), .REQ0_ACK(REQ0_ACK),
    .REQ1_VLD(REQ1_VLD), .REQ1_DATA(REQ1_DATA), .REQ1_TWO(REQ1_TWO), .REQ1_ACK(REQ1_ACK),
    .W_FULL(W_FULL), .WR_DATA(WR_DATA), .W_INC(W_INC), .BUSY(BUSY)
  );

  always #5 W_CLK = ~W_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge W_CLK);
    #1;
  endtask

  // Scoreboard monitor: compares every FIFO write and every grant pulse
  // against the expectations queued by the stimulus.
  always @(negedge W_CLK) begin
    if (W_RST) begin
      if (W_INC && W_FULL) chk("w_inc_while_full", 1, 0);
      if (REQ0_ACK && REQ1_ACK) chk("double_ack", 1, 0);
      if (W_INC) begin
        if (exp_bytes.size() == 0) chk("unexpected_write", {24'h0, WR_DATA}, 32'hFFFF_FFFF);
        else chk("wr_data", {24'h0, WR_DATA}, {24'h0, exp_bytes.pop_front()});
      end
      if (REQ0_ACK || REQ1_ACK) begin
        if (exp_grants.size() == 0) chk("unexpected_ack", {31'h0, REQ1_ACK}, 32'hFFFF_FFFF);
        else chk("grant_order", {31'h0, REQ1_ACK}, exp_grants.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;

    // Reset state
    #2;
    chk("rst_ack0", REQ0_ACK, 0);
    chk("rst_ack1", REQ1_ACK, 0);
    chk("rst_wr_data", WR_DATA, 0);
    chk("rst_w_inc", W_INC, 0);
    chk("rst_busy", BUSY, 0);
    #20 W_RST = 1'b1;
    tick();

    // 1-byte frame from producer 0
    exp_grants.push_back(0);
    exp_bytes.push_back(8'hA5);
    REQ0_DATA = 16'h12A5; REQ0_TWO = 1'b0; REQ0_VLD = 1'b1;
    tick();
    chk("t1_ack0", REQ0_ACK, 1);
    chk("t1_busy", BUSY, 1);
    chk("t1_w_inc", W_INC, 1);
    REQ0_VLD = 1'b0;
    tick();
    chk("t1_busy_low", BUSY, 0);
    chk("t1_ack0_low", REQ0_ACK, 0);
    chk("t1_no_inc", W_INC, 0);

    // 2-byte frame from producer 1
    exp_grants.push_back(1);
    exp_bytes.push_back(8'hEF);
    exp_bytes.push_back(8'hBE);
    REQ1_DATA = 16'hBEEF; REQ1_TWO = 1'b1; REQ1_VLD = 1'b1;
    tick();
    chk("t2_ack1", REQ1_ACK, 1);
    chk("t2_inc_lo", W_INC, 1);
    REQ1_VLD = 1'b0;
    tick();
    chk("t2_inc_hi", W_INC, 1);
    chk("t2_ack1_low", REQ1_ACK, 0);
    tick();
    chk("t2_busy_low", BUSY, 0);

    // Contention from reset: producer 0 first, then alternating
    W_RST = 1'b0;
    #3 W_RST = 1'b1;
    tick();
    exp_grants.push_back(0); exp_bytes.push_back(8'h11);
    exp_grants.push_back(1); exp_bytes.push_back(8'hC2); exp_bytes.push_back(8'hD2);
    exp_grants.push_back(0); exp_bytes.push_back(8'h11);
    exp_grants.push_back(1); exp_bytes.push_back(8'hC2); exp_bytes.push_back(8'hD2);
    REQ0_DATA = 16'h0011; REQ0_TWO = 1'b0;
    REQ1_DATA = 16'hD2C2; REQ1_TWO = 1'b1;
    REQ0_VLD = 1'b1; REQ1_VLD = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        tick();
        if (REQ0_ACK || REQ1_ACK) got = 1'b1;
      end
      chk("t3_ack_seen", {31'h0, got}, 1);
    end
    REQ0_VLD = 1'b0; REQ1_VLD = 1'b0;
    repeat (4) tick();
    chk("t3_idle", BUSY, 0);

    // Stall in SEND_HI for 4 cycles
    exp_grants.push_back(0);
    exp_bytes.push_back(8'h44);
    exp_bytes.push_back(8'h33);
    REQ0_DATA = 16'h3344; REQ0_TWO = 1'b1; REQ0_VLD = 1'b1;
    tick();
    chk("t4_inc_lo", W_INC, 1);
    REQ0_VLD = 1'b0;
    tick();
    W_FULL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_stall_no_inc", W_INC, 0);
      chk("t4_stall_data", WR_DATA, 8'h33);
      tick();
    end
    W_FULL = 1'b0;
    #1;
    chk("t4_release_inc", W_INC, 1);
    chk("t4_release_data", WR_DATA, 8'h33);
    tick();
    chk("t4_busy_low", BUSY, 0);

    // Reset mid-frame in SEND_HI
    exp_grants.push_back(1);
    exp_bytes.push_back(8'h88);
    REQ1_DATA = 16'h7788; REQ1_TWO = 1'b1; REQ1_VLD = 1'b1;
    tick();
    REQ1_VLD = 1'b0;
    tick();
    chk("t5_in_hi", BUSY, 1);
    #1 W_RST = 1'b0;
    #1;
    chk("t5_rst_inc", W_INC, 0);
    chk("t5_rst_data", WR_DATA, 0);
    chk("t5_rst_busy", BUSY, 0);
    chk("t5_rst_acks", {REQ0_ACK, REQ1_ACK}, 0);
    #4 W_RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_quiet", W_INC, 0);
    end
    exp_grants.push_back(0);
    exp_bytes.push_back(8'h55);
    REQ0_DATA = 16'h0055; REQ0_TWO = 1'b0;
    REQ1_DATA = 16'h0066; REQ1_TWO = 1'b0;
    REQ0_VLD = 1'b1; REQ1_VLD = 1'b1;
    tick();
    chk("t5_tie_ack0", REQ0_ACK, 1);
    chk("t5_tie_ack1", REQ1_ACK, 0);
    REQ0_VLD = 1'b0; REQ1_VLD = 1'b0;
    repeat (3) tick();

    chk("sb_bytes_drained", exp_bytes.size(), 0);
    chk("sb_grants_drained", exp_grants.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
